// File: rtl/vigna_bus_pkg.sv
// ---------------------------------------------------------------------------
// vigna_bus_pkg
// Shared definitions for the vigna bus fabric blocks:
//   bus_state_t   - transaction FSM state encoding (IDLE, S1, S2, RESP)
//   BUS_ERR_DATA  - read data returned to the master on a slave timeout
//   hits_region() - address region decode helper (masked compare)
// ---------------------------------------------------------------------------
package vigna_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_RESP = 2'd3
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    function automatic logic hits_region(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// ---------------------------------------------------------------------------
// bus_timeout_ctr
// Counts consecutive cycles a slave has left a request unanswered.
// Only instantiated when BUS1TO2_TIMEOUT_EN is defined.
// Ports:
//   clk      - clock, rising edge
//   resetn   - synchronous, active-low reset (counter -> 0)
//   clear    - restart the count from zero
//   enable   - count this cycle (slave wait cycle without ready)
//   expired  - this enabled cycle is the TIMEOUT_CYCLES-th unanswered one
// ---------------------------------------------------------------------------
module bus_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Flag the limit one cycle early (combinationally) so the FSM leaves
    // the wait state exactly TIMEOUT_CYCLES cycles after entering it.
    assign expired = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/bus1to2.sv
// ---------------------------------------------------------------------------
// bus1to2
// One-master to two-slave bus splitter. A request is latched in IDLE,
// routed to slave 2 when (m_addr & S2_MASK) == S2_BASE, otherwise to
// slave 1, held until the slave answers, and returned to the master as a
// single-cycle m_ready pulse.
//
// Optional feature (macro BUS1TO2_TIMEOUT_EN): abort a slave wait after
// TIMEOUT_CYCLES cycles, returning BUS_ERR_DATA with m_err=1. Without the
// macro the block waits indefinitely and m_err is tied low.
//
// Ports:
//   clk, resetn                      - clock / synchronous active-low reset
//   m_valid, m_addr, m_wdata, m_wstrb- master request (sampled in IDLE only)
//   m_ready, m_rdata, m_err          - master response (registered)
//   sN_valid, sN_addr, sN_wdata,
//   sN_wstrb                         - slave N request (zero when not selected)
//   sN_ready, sN_rdata               - slave N response
// ---------------------------------------------------------------------------
module bus1to2
    import vigna_bus_pkg::*;
#(
    parameter logic [31:0] S2_BASE        = 32'h1000_0000,
    parameter logic [31:0] S2_MASK        = 32'hF000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m_valid,
    output logic        m_ready,
    input  logic [31:0] m_addr,
    output logic [31:0] m_rdata,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        m_err,

    output logic        s1_valid,
    input  logic        s1_ready,
    output logic [31:0] s1_addr,
    input  logic [31:0] s1_rdata,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,

    output logic        s2_valid,
    input  logic        s2_ready,
    output logic [31:0] s2_addr,
    input  logic [31:0] s2_rdata,
    output logic [31:0] s2_wdata,
    output logic [3:0]  s2_wstrb
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("bus1to2: TIMEOUT_CYCLES must be in 2..65535");
    end

    bus_state_t  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        m_ready_q;
    logic        s1_valid_q;
    logic        s2_valid_q;

    logic        s_ready;
    logic [31:0] s_rdata;
    logic        tmo;

    // Response from whichever slave the current state is talking to.
    assign s_ready = (state == ST_S1 && s1_ready) || (state == ST_S2 && s2_ready);
    assign s_rdata = (state == ST_S2) ? s2_rdata : s1_rdata;

`ifdef BUS1TO2_TIMEOUT_EN
    logic m_err_q;

    // Held clear while idle, so every S1/S2 visit starts counting from zero.
    bus_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state == ST_IDLE),
        .enable  ((state == ST_S1 || state == ST_S2) && !s_ready),
        .expired (tmo)
    );

    // tmo can only fire in a wait state, so m_err_q is high exactly in
    // the RESP cycle that follows a timeout.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_err_q <= 1'b0;
        end else begin
            m_err_q <= tmo;
        end
    end

    assign m_err = m_err_q;
`else
    assign tmo   = 1'b0;
    assign m_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            m_ready_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m_ready_q <= 1'b0;
                    if (m_valid) begin
                        addr_q  <= m_addr;
                        wdata_q <= m_wdata;
                        wstrb_q <= m_wstrb;
                        if (hits_region(m_addr, S2_BASE, S2_MASK)) begin
                            state      <= ST_S2;
                            s2_valid_q <= 1'b1;
                        end else begin
                            state      <= ST_S1;
                            s1_valid_q <= 1'b1;
                        end
                    end
                end

                ST_S1, ST_S2: begin
                    // A ready in the same cycle as expiry wins over the timeout.
                    if (s_ready) begin
                        rdata_q    <= (wstrb_q != 4'b0) ? 32'h0 : s_rdata;
                        s1_valid_q <= 1'b0;
                        s2_valid_q <= 1'b0;
                        m_ready_q  <= 1'b1;
                        state      <= ST_RESP;
                    end else if (tmo) begin
                        rdata_q    <= BUS_ERR_DATA;
                        s1_valid_q <= 1'b0;
                        s2_valid_q <= 1'b0;
                        m_ready_q  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    m_ready_q <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ready  = m_ready_q;
    assign m_rdata  = rdata_q;

    assign s1_valid = s1_valid_q;
    assign s1_addr  = s1_valid_q ? addr_q  : 32'h0;
    assign s1_wdata = s1_valid_q ? wdata_q : 32'h0;
    assign s1_wstrb = s1_valid_q ? wstrb_q : 4'h0;

    assign s2_valid = s2_valid_q;
    assign s2_addr  = s2_valid_q ? addr_q  : 32'h0;
    assign s2_wdata = s2_valid_q ? wdata_q : 32'h0;
    assign s2_wstrb = s2_valid_q ? wstrb_q : 4'h0;

endmodule

// File: tb/tb_bus1to2.sv
// ---------------------------------------------------------------------------
// tb_bus1to2
// Table-driven bench for bus1to2 plus hand-written sequences for
// back-to-back transfers, reset mid-transfer and timeout / indefinite wait.
// ---------------------------------------------------------------------------
module tb_bus1to2;

`ifdef BUS1TO2_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 256;
`endif

    logic        clk;
    logic        resetn;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_rdata;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_err;
    logic        s1_valid, s2_valid;
    logic        s1_ready, s2_ready;
    logic [31:0] s1_addr, s2_addr;
    logic [31:0] s1_rdata, s2_rdata;
    logic [31:0] s1_wdata, s2_wdata;
    logic [3:0]  s1_wstrb, s2_wstrb;

    int checks   = 0;
    int failures = 0;

    bus1to2 #(
        .S2_BASE        (32'h1000_0000),
        .S2_MASK        (32'hF000_0000),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_err    (m_err),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_addr  (s1_addr),
        .s1_rdata (s1_rdata),
        .s1_wdata (s1_wdata),
        .s1_wstrb (s1_wstrb),
        .s2_valid (s2_valid),
        .s2_ready (s2_ready),
        .s2_addr  (s2_addr),
        .s2_rdata (s2_rdata),
        .s2_wdata (s2_wdata),
        .s2_wstrb (s2_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;     // wait cycles before slave ready
        logic [31:0] srdata;    // data driven by the selected slave
        int          tgt;       // expected slave (1 or 2)
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        m_valid  = 1'b1;
        m_addr   = v.addr;
        m_wdata  = v.wdata;
        m_wstrb  = v.wstrb;
        s1_rdata = (v.tgt == 1) ? v.srdata : ~v.srdata;
        s2_rdata = (v.tgt == 2) ? v.srdata : ~v.srdata;
        chk({t, "_idle_ready"}, {31'b0, m_ready}, 32'h0);
        step();
        // Master side changes after accept must not leak into the slave request.
        m_valid = 1'b0;
        m_addr  = 32'hFFFF_FFFF;
        m_wdata = 32'h0;
        m_wstrb = 4'h0;
        for (int c = 0; c <= v.delay; c++) begin
            if (v.tgt == 1) begin
                chk({t, "_s1_valid"}, {31'b0, s1_valid}, 32'h1);
                chk({t, "_s1_addr"},  s1_addr,  v.addr);
                chk({t, "_s1_wdata"}, s1_wdata, v.wdata);
                chk({t, "_s1_wstrb"}, {28'b0, s1_wstrb}, {28'b0, v.wstrb});
                chk({t, "_s2_valid"}, {31'b0, s2_valid}, 32'h0);
                chk({t, "_s2_addr"},  s2_addr,  32'h0);
            end else begin
                chk({t, "_s2_valid"}, {31'b0, s2_valid}, 32'h1);
                chk({t, "_s2_addr"},  s2_addr,  v.addr);
                chk({t, "_s2_wdata"}, s2_wdata, v.wdata);
                chk({t, "_s2_wstrb"}, {28'b0, s2_wstrb}, {28'b0, v.wstrb});
                chk({t, "_s1_valid"}, {31'b0, s1_valid}, 32'h0);
                chk({t, "_s1_addr"},  s1_addr,  32'h0);
            end
            chk({t, "_wait_ready"}, {31'b0, m_ready}, 32'h0);
            if (c == v.delay) begin
                if (v.tgt == 1) s1_ready = 1'b1;
                else            s2_ready = 1'b1;
            end
            step();
            s1_ready = 1'b0;
            s2_ready = 1'b0;
        end
        chk({t, "_resp_ready"}, {31'b0, m_ready}, 32'h1);
        chk({t, "_resp_rdata"}, m_rdata, v.exp_rdata);
        chk({t, "_resp_err"},   {31'b0, m_err}, 32'h0);
        chk({t, "_resp_s1v"},   {31'b0, s1_valid}, 32'h0);
        chk({t, "_resp_s2v"},   {31'b0, s2_valid}, 32'h0);
        step();
        chk({t, "_pulse_end"},  {31'b0, m_ready}, 32'h0);
        chk({t, "_rdata_hold"}, m_rdata, v.exp_rdata);
    endtask

    initial begin
        int hits;
        int bad;

        vecs[0] = '{32'h0000_0040, 32'h0000_0000, 4'h0, 0, 32'h1234_5678, 1, 32'h1234_5678};
        vecs[1] = '{32'h1000_0008, 32'hCAFE_F00D, 4'hF, 3, 32'h5555_AAAA, 2, 32'h0000_0000};
        vecs[2] = '{32'h1FFF_FFFC, 32'h0000_0000, 4'h0, 1, 32'hA5A5_5A5A, 2, 32'hA5A5_5A5A};
        vecs[3] = '{32'h2000_0000, 32'h0000_0000, 4'h0, 2, 32'h0F0F_0F0F, 1, 32'h0F0F_0F0F};
        vecs[4] = '{32'h0000_0010, 32'h0000_00FF, 4'h1, 0, 32'h7777_7777, 1, 32'h0000_0000};
        vecs[5] = '{32'hF000_0000, 32'h0000_0000, 4'h0, 0, 32'h8888_1111, 1, 32'h8888_1111};
        vecs[6] = '{32'h0FFF_FFFC, 32'h0000_0000, 4'h0, 0, 32'h3C3C_C3C3, 1, 32'h3C3C_C3C3};

        resetn   = 1'b0;
        m_valid  = 1'b0;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        m_wstrb  = 4'h0;
        s1_ready = 1'b0;
        s2_ready = 1'b0;
        s1_rdata = 32'h0;
        s2_rdata = 32'h0;
        repeat (3) step();

        // Reset state
        chk("rst_m_ready",  {31'b0, m_ready},  32'h0);
        chk("rst_m_err",    {31'b0, m_err},    32'h0);
        chk("rst_m_rdata",  m_rdata,           32'h0);
        chk("rst_s1_valid", {31'b0, s1_valid}, 32'h0);
        chk("rst_s2_valid", {31'b0, s2_valid}, 32'h0);
        chk("rst_s1_addr",  s1_addr,           32'h0);
        chk("rst_s2_addr",  s2_addr,           32'h0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_txn(i, vecs[i]);
        end

        // Back-to-back: slave 1 then slave 2 with m_valid held high
        m_valid  = 1'b1;
        m_addr   = 32'h0000_0100;
        m_wstrb  = 4'h0;
        s1_rdata = 32'h1111_1111;
        s2_rdata = 32'h2222_2222;
        step();
        chk("b2b_s1_valid", {31'b0, s1_valid}, 32'h1);
        chk("b2b_s1_addr",  s1_addr,           32'h0000_0100);
        chk("b2b_s2_idle",  {31'b0, s2_valid}, 32'h0);
        s1_ready = 1'b1;
        step();
        s1_ready = 1'b0;
        chk("b2b_r1_ready", {31'b0, m_ready}, 32'h1);
        chk("b2b_r1_rdata", m_rdata,          32'h1111_1111);
        m_addr = 32'h1000_0100;
        step();
        chk("b2b_gap_ready", {31'b0, m_ready},  32'h0);
        chk("b2b_gap_s1v",   {31'b0, s1_valid}, 32'h0);
        chk("b2b_gap_s2v",   {31'b0, s2_valid}, 32'h0);
        step();
        chk("b2b_s2_valid", {31'b0, s2_valid}, 32'h1);
        chk("b2b_s2_addr",  s2_addr,           32'h1000_0100);
        chk("b2b_s1_idle",  {31'b0, s1_valid}, 32'h0);
        m_valid  = 1'b0;
        s2_ready = 1'b1;
        step();
        s2_ready = 1'b0;
        chk("b2b_r2_ready", {31'b0, m_ready}, 32'h1);
        chk("b2b_r2_rdata", m_rdata,          32'h2222_2222);
        step();
        chk("b2b_end_ready", {31'b0, m_ready}, 32'h0);

        // Reset during a slave-2 wait
        m_valid = 1'b1;
        m_addr  = 32'h1000_0000;
        step();
        m_valid = 1'b0;
        chk("rstmid_s2_valid", {31'b0, s2_valid}, 32'h1);
        step();
        chk("rstmid_s2_hold", {31'b0, s2_valid}, 32'h1);
        resetn = 1'b0;
        step();
        chk("rstmid_s2_drop", {31'b0, s2_valid}, 32'h0);
        chk("rstmid_s2_addr", s2_addr,           32'h0);
        resetn = 1'b1;
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_ready !== 1'b0) hits++;
            step();
        end
        chk("rstmid_no_ready", 32'(hits), 32'h0);
        run_txn(7, '{32'h0000_0000, 32'h0, 4'h0, 0, 32'h0BAD_C0DE, 1, 32'h0BAD_C0DE});

`ifdef BUS1TO2_TIMEOUT_EN
        // Slave 1 never answers: abort after TIMEOUT_CYCLES wait cycles
        m_valid = 1'b1;
        m_addr  = 32'h0000_0040;
        step();
        m_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("tmo_s1_valid", {31'b0, s1_valid}, 32'h1);
            chk("tmo_wait_rdy", {31'b0, m_ready},  32'h0);
            step();
        end
        chk("tmo_s1_drop", {31'b0, s1_valid}, 32'h0);
        chk("tmo_ready",   {31'b0, m_ready},  32'h1);
        chk("tmo_err",     {31'b0, m_err},    32'h1);
        chk("tmo_rdata",   m_rdata,           32'hDEAD_BEEF);
        step();
        chk("tmo_ready_end", {31'b0, m_ready}, 32'h0);
        chk("tmo_err_end",   {31'b0, m_err},   32'h0);
`else
        // Slave 1 never answers: the request is held indefinitely
        m_valid = 1'b1;
        m_addr  = 32'h0000_0040;
        step();
        m_valid = 1'b0;
        bad  = 0;
        hits = 0;
        for (int c = 0; c < 1000; c++) begin
            if (s1_valid !== 1'b1) bad++;
            if (m_ready !== 1'b0 || m_err !== 1'b0) hits++;
            step();
        end
        chk("hang_s1_valid", 32'(bad),  32'h0);
        chk("hang_no_ready", 32'(hits), 32'h0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("hang_rst_s1v", {31'b0, s1_valid}, 32'h0);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus1to2.md
BUS1TO2 -- requirements
Module: bus1to2

Interface
REQ-001 SHALL have parameter S2_BASE, default 32'h1000_0000: slave-2 region base address.
REQ-002 SHALL have parameter S2_MASK, default 32'hF000_0000: address bits compared against S2_BASE.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: slave-wait limit (timeout build only), range 2..65535.
REQ-004 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have ports m_valid (in, 1), m_ready (out, 1), m_addr (in, 32), m_rdata (out, 32), m_wdata (in, 32), m_wstrb (in, 4), m_err (out, 1): upstream master side.
REQ-007 SHALL have ports s1_valid/s2_valid (out, 1), s1_ready/s2_ready (in, 1), s1_addr/s2_addr (out, 32), s1_rdata/s2_rdata (in, 32), s1_wdata/s2_wdata (out, 32), s1_wstrb/s2_wstrb (out, 4): downstream slave sides.

Function
REQ-008 SHALL decode target as slave 2 when (m_addr & S2_MASK) == S2_BASE, otherwise slave 1.
REQ-009 SHALL implement FSM states IDLE, S1, S2, RESP.
REQ-010 IDLE: on m_valid=1, SHALL latch addr/wdata/wstrb and decoded target, then go to S1 or S2 next cycle; m_ready=0.
REQ-011 S1/S2: SHALL hold selected sN_valid=1 with latched addr/wdata/wstrb; non-selected slave sees valid=0 and addr/wdata/wstrb=0.
REQ-012 S1/S2: on sN_ready=1, SHALL capture sN_rdata (or 0 if latched wstrb!=0), drop sN_valid next cycle, go to RESP.
REQ-013 RESP: SHALL assert m_ready=1 for exactly one cycle with m_rdata = captured data, then return to IDLE.
REQ-014 Latency: slave ready in first S-cycle gives m_ready exactly 2 cycles after the IDLE accept edge (3 cycles total, m_valid to m_ready inclusive).
REQ-015 Master inputs SHALL be ignored outside IDLE; a transaction once accepted is not abortable, and m_ready pulses even if m_valid dropped.
REQ-016 m_valid high in the IDLE cycle after RESP SHALL be accepted as a new transaction (back-to-back, 1 idle cycle).
REQ-017 m_rdata SHALL hold its last value until the next capture; m_err=0 except as in REQ-021.

Reset
REQ-018 resetn=0 SHALL force IDLE, m_ready=0, m_err=0, m_rdata=0, all sN_valid=0, latched fields=0, timeout counter=0.
REQ-019 Reset mid-transaction SHALL drop sN_valid on the next edge; no m_ready pulse for the aborted transfer.

Configuration
REQ-020 Macro BUS1TO2_TIMEOUT_EN SHALL compile the timeout feature in.
REQ-021 With it, a counter SHALL clear on entry to S1/S2 and increment each S-cycle without ready. On reaching TIMEOUT_CYCLES, the block SHALL drop sN_valid, go to RESP with m_rdata=32'hDEAD_BEEF and m_err=1 for the RESP cycle.
REQ-022 Without it, the block SHALL wait indefinitely in S1/S2, have no counter, and tie m_err to 0.

Structure
REQ-023 Shared package vigna_bus_pkg SHALL hold FSM state encoding and the BUS_ERR_DATA constant (32'hDEAD_BEEF).
REQ-024 Timeout counter SHALL be sub-module bus_timeout_ctr (clear, enable, expired), instantiated only under BUS1TO2_TIMEOUT_EN.

Verification
REQ-025 Read 0x0000_0040, s1_ready immediate, s1_rdata=0x1234_5678: s1_valid one cycle, m_ready 2 cycles after accept, m_rdata=0x1234_5678, s2_valid never high.
REQ-026 Write 0x1000_0008, wstrb=4'hF, wdata=0xCAFE_F00D, s2_ready after 3 cycles: s2 sees exact addr/wdata/wstrb for 4 cycles, m_rdata=0, m_ready single pulse.
REQ-027 Back-to-back reads to slave 1 then slave 2 with m_valid held high: second accepted in the IDLE cycle after RESP, correct routing and data each.
REQ-028 Timeout build, TIMEOUT_CYCLES=4, s1_ready stuck 0: s1_valid drops after 4 cycles, m_ready=1, m_err=1, m_rdata=0xDEAD_BEEF. Non-timeout build: s1_valid held 1000 cycles, no m_ready.
REQ-029 resetn=0 during S2 wait: s2_valid=0 next cycle, m_ready never pulses. A subsequent read to 0x0000_0000 completes normally.
